// File: rtl/ram_responder_if.sv
// ram_responder_if
//   Single-word memory port between the arbiter (master) and the RAM
//   responder (slave).
//   ramREN   : read request, held until ACCESS
//   ramWEN   : write request, held until ACCESS
//   ramaddr  : byte address, word index is ramaddr[31:2]
//   ramstore : write data
//   ramstate : 2'd0 FREE, 2'd1 BUSY, 2'd2 ACCESS, 2'd3 ERROR
//   ramload  : read data, valid while ramstate == ACCESS after a read
interface ram_responder_if;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [1:0]  ramstate;
    logic [31:0] ramload;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramstate, ramload
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramstate, ramload
    );
endinterface

// File: rtl/ram_responder.sv
// ram_responder
//   Cycle-accurate RAM model answering single-word read/write requests with
//   a programmable number of BUSY cycles before a one-cycle ACCESS.
//   Parameters:
//     LAT   : BUSY cycles before ACCESS (0..15); 0 gives ACCESS next cycle
//     DEPTH : number of 32-bit words
//   Ports:
//     CLK  : clock, rising edge
//     nRST : asynchronous active-low reset (clears state and memory)
//     bus  : ram_responder_if.slave memory port
//   Build option:
//     RAM_ALIGN_CHECK_EN : when defined, a request with ramaddr[1:0] != 0
//                          is answered with ERROR; otherwise those bits are
//                          ignored and the access is word-aligned.
module ram_responder #(
    parameter int LAT   = 2,
    parameter int DEPTH = 1024
) (
    input logic              CLK,
    input logic              nRST,
    ram_responder_if.slave   bus
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramState_e;

    localparam int CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LAT);

    ramState_e        state;
    ramState_e        nextState;
    ramState_e        freshState;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [31:0]      capAddr;
    logic [31:0]      capStore;
    logic             capRen;
    logic             capWen;
    logic [31:0]      loadReg;
    logic [31:0]      mem [DEPTH];

    logic             reqAny;
    logic             reqIllegal;
    logic             reqChanged;
    logic             idxOk;
    logic             alignOk;
    logic             loadReq;
    logic             doRead;
    logic             doWrite;
    logic [IDX_W-1:0] idx;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign reqAny = bus.ramREN | bus.ramWEN;
    assign idxOk  = (bus.ramaddr[31:2] < 30'(DEPTH));
    assign idx    = bus.ramaddr[IDX_W+1:2];

`ifdef RAM_ALIGN_CHECK_EN
    assign alignOk = (bus.ramaddr[1:0] == 2'b00);
`else
    assign alignOk = 1'b1;
`endif

    assign reqIllegal = (bus.ramREN & bus.ramWEN) | ~idxOk | ~alignOk;

    // Any difference from the captured request restarts the latency.
    assign reqChanged = (bus.ramaddr  != capAddr)  ||
                        (bus.ramstore != capStore) ||
                        (bus.ramREN   != capRen)   ||
                        (bus.ramWEN   != capWen);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= FREE;
            cnt      <= '0;
            capAddr  <= '0;
            capStore <= '0;
            capRen   <= 1'b0;
            capWen   <= 1'b0;
        end else begin
            state <= nextState;
            cnt   <= cntNext;
            if (loadReq) begin
                capAddr  <= bus.ramaddr;
                capStore <= bus.ramstore;
                capRen   <= bus.ramREN;
                capWen   <= bus.ramWEN;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // freshState is the answer to the inputs seen as a brand-new request;
    // FREE, ACCESS and ERROR all re-evaluate this way, so a held request is
    // serviced again after ACCESS.
    always_comb begin
        freshState = FREE;
        if (reqAny) begin
            if (reqIllegal)
                freshState = ERROR;
            else if (LAT == 0)
                freshState = ACCESS;
            else
                freshState = BUSY;
        end

        nextState = freshState;
        if (state == BUSY && reqAny && !reqChanged)
            nextState = (cnt == CNT_W'(1)) ? ACCESS : BUSY;
    end

    // ------------------------------------------------------------------
    // Output / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        loadReq = ((freshState == BUSY) || (freshState == ACCESS)) &&
                  !(state == BUSY && !reqChanged);

        cntNext = '0;
        if (loadReq)
            cntNext = LAT_LOAD;
        else if (nextState == BUSY)
            cntNext = cnt - CNT_W'(1);

        // ACCESS is only reachable with exactly one of REN/WEN high and an
        // in-range index, so these never fire on an illegal request.
        doRead  = (nextState == ACCESS) && bus.ramREN;
        doWrite = (nextState == ACCESS) && bus.ramWEN;
    end

    // ------------------------------------------------------------------
    // Memory array and read-data register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            loadReg <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (doRead)
                loadReg <= mem[idx];
            if (doWrite)
                mem[idx] <= bus.ramstore;
        end
    end

    assign bus.ramstate = state;
    assign bus.ramload  = loadReg;

endmodule
